// File: rtl/wr_channel_merger_pkg.sv
// Shared definitions for the write-channel merger: channel count, channel
// index type, default data width and the round-robin successor function.
package wr_channel_merger_pkg;

  localparam int NCH        = 3;
  localparam int DEF_DATA_W = 8;

  typedef logic [1:0] chan_t;

  // Successor of channel k in the round-robin ring 0 -> 1 -> 2 -> 0.
  function automatic chan_t next_rr(input chan_t k);
    if (k >= chan_t'(NCH - 1))
      return chan_t'(0);
    else
      return chan_t'(k + chan_t'(1));
  endfunction

endpackage

// File: rtl/wr_channel_merger_chan_fifo.sv
// Per-channel FIFO. Pointers wrap naturally because DEPTH is a power of two;
// the occupancy count is one bit wider so full and empty are distinct.
// A push while full is honoured only when a pop happens on the same edge.
module chan_fifo
  import wr_channel_merger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wr_channel_merger.sv
// Merges three write channels into one valid/ready stream tagged with the
// source channel. Each channel is buffered in its own FIFO; a round-robin
// arbiter picks the next non-empty FIFO whenever the output register can
// take a word. Dropped writes raise sticky per-channel overflow flags.
module wr_channel_merger
  import wr_channel_merger_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wen0,
  input  logic              wen1,
  input  logic              wen2,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              freeze,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic [2:0]        ovf
);

  logic [DATA_W-1:0] wdata [NCH];
  logic [DATA_W-1:0] head  [NCH];
  logic [NCH-1:0]    wen;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    push;
  logic [NCH-1:0]    pop;

  chan_t             rr;
  chan_t             gnt;
  logic              gnt_vld;
  logic              load;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  chan_t             chan_p1;
  logic [NCH-1:0]    ovf_q;

  assign wen      = {wen2, wen1, wen0};
  assign wdata[0] = data0;
  assign wdata[1] = data1;
  assign wdata[2] = data2;

  // Channel FIFOs
  for (genvar i = 0; i < NCH; i++) begin : g_fifo
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push[i]),
      .push_data (wdata[i]),
      .pop       (pop[i]),
      .head_data (head[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );

    // A full FIFO still accepts a write when it is being popped this edge.
    assign pop[i]  = load && (gnt == chan_t'(i));
    assign push[i] = wen[i] && (!full[i] || pop[i]);
  end

  // Round-robin search: first non-empty FIFO at or after rr.
  always_comb begin
    chan_t cand;
    gnt_vld = 1'b0;
    gnt     = rr;
    cand    = rr;
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
      cand = next_rr(cand);
    end
  end

  // A new word enters the output register only when it is free or being
  // drained this edge, and freeze is low.
  assign load = !freeze && (!vld_p1 || out_ready) && gnt_vld;

  // Round-robin pointer advances past the granted channel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rr <= chan_t'(0);
    else if (load)
      rr <= next_rr(gnt);
  end

  // ---- stage p1: output register ----
  // Load a granted word, otherwise retire the current one once accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= chan_t'(0);
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= head[gnt];
      chan_p1 <= gnt;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Sticky overflow flags: any write strobe that was not accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ovf_q <= '0;
    else
      ovf_q <= ovf_q | (wen & ~push);
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wr_channel_merger.sv
// Scenario bench for wr_channel_merger: expected words are queued as
// stimulus is driven and compared when the DUT hands them over.
module tb_wr_channel_merger;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       wen0 = 1'b0, wen1 = 1'b0, wen2 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0, data2 = '0;
  logic       freeze = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic [2:0] ovf;

  int         nvec = 0;
  int         nmis = 0;
  logic [9:0] sb [$];

  always #5 clk = ~clk;

  wr_channel_merger #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wen0      (wen0),
    .wen1      (wen1),
    .wen2      (wen2),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .ovf       (ovf)
  );

  task automatic do_reset();
    resetn = 1'b0;
    wen0 = 0; wen1 = 0; wen2 = 0;
    data0 = 0; data1 = 0; data2 = 0;
    freeze = 0; out_ready = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    nvec++; if (ovf !== 3'b000) begin nmis++; $display("FAIL reset_ovf: got %b want 000", ovf); end
    nvec++; if (out_data !== 8'h00) begin nmis++; $display("FAIL reset_data: got %h want 00", out_data); end
    nvec++; if (out_chan !== 2'd0) begin nmis++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    do_reset();
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL reset_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    logic [9:0] exp;
    do_reset();
    out_ready = 1;
    wen1 = 1; data1 = 8'h5A; sb.push_back({2'd1, 8'h5A});
    @(negedge clk);
    wen1 = 0;
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL single_early: got valid %b want 0", out_valid); end
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
    nvec++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp)
      begin nmis++; $display("FAIL single_word: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", out_valid, out_chan, out_data, exp[9:8], exp[7:0]); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL single_once: got valid %b want 0", out_valid); end
  endtask

  task automatic test_fairness();
    logic [9:0] exp;
    int ncyc;
    do_reset();
    out_ready = 1;
    {wen0, wen1, wen2} = 3'b111;
    data0 = 8'h10; data1 = 8'h20; data2 = 8'h30;
    sb.push_back({2'd0, 8'h10}); sb.push_back({2'd1, 8'h20}); sb.push_back({2'd2, 8'h30});
    @(negedge clk);
    data0 = 8'h11; data1 = 8'h21; data2 = 8'h31;
    sb.push_back({2'd0, 8'h11}); sb.push_back({2'd1, 8'h21}); sb.push_back({2'd2, 8'h31});
    @(negedge clk);
    {wen0, wen1, wen2} = 3'b000;
    ncyc = 0;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        nvec++; if ({out_chan, out_data} !== exp)
          begin nmis++; $display("FAIL fair_word: got ch=%0d d=%h want ch=%0d d=%h", out_chan, out_data, exp[9:8], exp[7:0]); end
      end
      ncyc++;
      @(negedge clk);
    end
    nvec++; if (sb.size() != 0 || ncyc != 6)
      begin nmis++; $display("FAIL fair_rate: got %0d cycles %0d left want 6 cycles 0 left", ncyc, sb.size()); end
  endtask

  task automatic test_overflow();
    logic [9:0] exp;
    do_reset();
    out_ready = 0;
    wen2 = 1;
    for (int i = 0; i < 6; i++) begin
      data2 = 8'(i);
      if (i < 5) sb.push_back({2'd2, 8'(i)});
      @(negedge clk);
    end
    wen2 = 0;
    nvec++; if (ovf !== 3'b100) begin nmis++; $display("FAIL ovf_flag: got %b want 100", ovf); end
    out_ready = 1;
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        nvec++; if ({out_chan, out_data} !== exp)
          begin nmis++; $display("FAIL ovf_word: got ch=%0d d=%h want ch=%0d d=%h", out_chan, out_data, exp[9:8], exp[7:0]); end
      end
      @(negedge clk);
    end
    nvec++; if (sb.size() != 0) begin nmis++; $display("FAIL ovf_drain: got %0d left want 0", sb.size()); end
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL ovf_lost: got valid %b want 0", out_valid); end
    nvec++; if (ovf !== 3'b100) begin nmis++; $display("FAIL ovf_sticky: got %b want 100", ovf); end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    do_reset();
    out_ready = 0;
    wen0 = 1; data0 = 8'hA5; sb.push_back({2'd0, 8'hA5});
    @(negedge clk);
    data0 = 8'hB6; sb.push_back({2'd0, 8'hB6});
    @(negedge clk);
    wen0 = 0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd0)
        begin nmis++; $display("FAIL bp_hold: got v=%b ch=%0d d=%h want v=1 ch=0 d=a5", out_valid, out_chan, out_data); end
      @(negedge clk);
    end
    out_ready = 1;
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
    nvec++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp)
      begin nmis++; $display("FAIL bp_first: got ch=%0d d=%h want ch=%0d d=%h", out_chan, out_data, exp[9:8], exp[7:0]); end
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
    nvec++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp)
      begin nmis++; $display("FAIL bp_next: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", out_valid, out_chan, out_data, exp[9:8], exp[7:0]); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL bp_end: got valid %b want 0", out_valid); end
  endtask

  task automatic test_freeze_complete();
    logic [9:0] exp;
    do_reset();
    out_ready = 0;
    wen0 = 1; data0 = 8'h61; sb.push_back({2'd0, 8'h61});
    @(negedge clk);
    data0 = 8'h62; sb.push_back({2'd0, 8'h62});
    @(negedge clk);
    wen0 = 0;
    freeze = 1; out_ready = 1;
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
    nvec++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp)
      begin nmis++; $display("FAIL frz_present: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[7:0]); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL frz_drop: got valid %b want 0", out_valid); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL frz_stall: got valid %b want 0", out_valid); end
    freeze = 0;
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
    nvec++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp)
      begin nmis++; $display("FAIL frz_resume: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp[7:0]); end
    @(negedge clk);
  endtask

  task automatic test_freeze_full();
    logic [9:0] exp;
    do_reset();
    out_ready = 0; freeze = 1; wen0 = 1;
    for (int i = 0; i < 4; i++) begin
      data0 = 8'h40 + 8'(i);
      sb.push_back({2'd0, 8'h40 + 8'(i)});
      @(negedge clk);
    end
    data0 = 8'h44;
    @(negedge clk);
    wen0 = 0;
    nvec++; if (ovf !== 3'b001) begin nmis++; $display("FAIL full_ovf: got %b want 001", ovf); end
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL full_frozen: got valid %b want 0", out_valid); end
    freeze = 0; out_ready = 1; wen0 = 1; data0 = 8'h45;
    sb.push_back({2'd0, 8'h45});
    @(negedge clk);
    wen0 = 0;
    nvec++; if (ovf !== 3'b001) begin nmis++; $display("FAIL full_pushpop: got %b want 001", ovf); end
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        nvec++; if ({out_chan, out_data} !== exp)
          begin nmis++; $display("FAIL full_word: got ch=%0d d=%h want ch=%0d d=%h", out_chan, out_data, exp[9:8], exp[7:0]); end
      end
      @(negedge clk);
    end
    nvec++; if (sb.size() != 0 || out_valid !== 1'b0)
      begin nmis++; $display("FAIL full_drain: got %0d left v=%b want 0 left v=0", sb.size(), out_valid); end
  endtask

  task automatic test_async_reset();
    logic [9:0] exp;
    do_reset();
    out_ready = 0; wen1 = 1;
    for (int i = 0; i < 7; i++) begin
      data1 = 8'h80 + 8'(i);
      @(negedge clk);
    end
    wen1 = 0;
    nvec++; if (ovf !== 3'b010 || out_valid !== 1'b1)
      begin nmis++; $display("FAIL ar_pre: got ovf=%b v=%b want ovf=010 v=1", ovf, out_valid); end
    #2 resetn = 1'b0;
    #1;
    nvec++; if (out_valid !== 1'b0 || ovf !== 3'b000 || out_data !== 8'h00 || out_chan !== 2'd0)
      begin nmis++; $display("FAIL ar_now: got v=%b ovf=%b d=%h ch=%0d want 0 000 00 0", out_valid, ovf, out_data, out_chan); end
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    out_ready = 1;
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL ar_empty: got valid %b want 0", out_valid); end
    wen0 = 1; data0 = 8'h77; sb.push_back({2'd0, 8'h77});
    @(negedge clk);
    wen0 = 0;
    @(negedge clk);
    exp = (sb.size() > 0) ? sb.pop_front() : 10'h3ff;
    nvec++; if (out_valid !== 1'b1 || {out_chan, out_data} !== exp)
      begin nmis++; $display("FAIL ar_first: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", out_valid, out_chan, out_data, exp[9:8], exp[7:0]); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL ar_after: got valid %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_overflow();
    test_backpressure();
    test_freeze_complete();
    test_freeze_full();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
